// File: rtl/cim_param_rx_if.sv
// Broadcast parameter bus shared by all CiM receivers; the sender drives it and
// every receiver listens through the slave modport.
interface cim_param_rx_if #(
    parameter int N_STORAGE = 16
);
    logic        [4:0]           bus_op;
    logic signed [N_STORAGE-1:0] bus_data_0;
    logic signed [N_STORAGE-1:0] bus_data_1;
    logic signed [N_STORAGE-1:0] bus_data_2;
    logic        [5:0]           bus_target_or_sender;

    modport master (
        output bus_op, bus_data_0, bus_data_1, bus_data_2, bus_target_or_sender
    );

    modport slave (
        input bus_op, bus_data_0, bus_data_1, bus_data_2, bus_target_or_sender
    );
endinterface

// File: rtl/cim_param_rx.sv
// Parameter-stream receiver for one CiM: accepts up to three words per bus op into a
// 6-entry FIFO and drains them one per cycle into the local parameter memory.
module cim_param_rx #(
    parameter int  ID        = 0,
    parameter int  N_STORAGE = 16,
    parameter int  MEM_DEPTH = 528,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cim_param_rx_if.slave               bus,
    input  logic                        err_clr,
    output logic                        mem_wr_en,
    output logic        [ADDR_W-1:0]    mem_wr_addr,
    output logic signed [N_STORAGE-1:0] mem_wr_data,
    output logic                        busy,
    output logic                        load_done,
    output logic                        err
);

    localparam logic [4:0]           OP_START  = 5'd1;
    localparam logic [4:0]           OP_STREAM = 5'd2;
    localparam int                   FIFO_D    = 6;
    localparam logic [2:0]           FIFO_FULL = 3'd6;
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [N_STORAGE-1:0] REM_THREE = N_STORAGE'(3);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t                      state_q;
    logic [N_STORAGE-1:0]        rem_q;
    logic [ADDR_W-1:0]           wptr_q, wptr_d;
    logic [2:0]                  rd_q, rd_d;
    logic [2:0]                  wr_q, wr_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic signed [N_STORAGE-1:0] fifo_q [FIFO_D];

    logic                        mem_wr_en_q;
    logic [ADDR_W-1:0]           mem_wr_addr_q;
    logic signed [N_STORAGE-1:0] mem_wr_data_q;
    logic                        load_done_q;
    logic                        err_q, err_d;

    logic signed [N_STORAGE-1:0] words [3];
    logic                        for_me, is_start, is_stream, flush, pop;
    logic                        overflow, wrap_hit, err_set;
    logic [2:0]                  k, push_req, cnt_after_pop, free, n_acc;
    logic [N_STORAGE-1:0]        k_ext;

    // Circular index into the 6-entry buffer; base<=5 and off<=3 so one fold suffices.
    function automatic logic [2:0] fifo_idx(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 4'd6) begin
            sum = sum - 4'd6;
        end
        return sum[2:0];
    endfunction

    always_comb begin
        words[0]  = bus.bus_data_0;
        words[1]  = bus.bus_data_1;
        words[2]  = bus.bus_data_2;
        for_me    = (bus.bus_target_or_sender == 6'(ID));
        is_start  = for_me && (bus.bus_op == OP_START);
        is_stream = for_me && (bus.bus_op == OP_STREAM);

        // A restart discards buffered words, so the head is not written that cycle.
        flush = is_start && (state_q != IDLE);
        pop   = (cnt_q != 3'd0) && !flush;

        k        = (rem_q >= REM_THREE) ? 3'd3 : rem_q[2:0];
        k_ext    = {{(N_STORAGE-3){1'b0}}, k};
        push_req = (is_stream && (state_q == STREAM)) ? k : 3'd0;

        // Free space is evaluated after this cycle's pop.
        cnt_after_pop = cnt_q - {2'b00, pop};
        free          = FIFO_FULL - cnt_after_pop;
        overflow      = (push_req > free);
        n_acc         = overflow ? free : push_req;

        wrap_hit = pop && (wptr_q >= LAST_ADDR);
        err_set  = (is_stream && (state_q != STREAM)) || flush || overflow || wrap_hit;
        err_d    = err_set || (err_q && !err_clr);

        if (flush) begin
            cnt_d = 3'd0;
            rd_d  = 3'd0;
            wr_d  = 3'd0;
        end else begin
            cnt_d = cnt_after_pop + n_acc;
            rd_d  = pop ? fifo_idx(rd_q, 3'd1) : rd_q;
            wr_d  = fifo_idx(wr_q, n_acc);
        end

        if (is_start) begin
            wptr_d = bus.bus_data_0[ADDR_W-1:0];
        end else if (pop) begin
            wptr_d = wrap_hit ? '0 : wptr_q + 1'b1;
        end else begin
            wptr_d = wptr_q;
        end
    end

    // Buffer storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (3'(i) < n_acc) begin
                fifo_q[fifo_idx(wr_q, 3'(i))] <= words[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            wptr_q        <= '0;
            rd_q          <= 3'd0;
            wr_q          <= 3'd0;
            cnt_q         <= 3'd0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            load_done_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            wptr_q      <= wptr_d;
            err_q       <= err_d;
            mem_wr_en_q <= pop;
            load_done_q <= 1'b0;
            if (pop) begin
                mem_wr_addr_q <= wptr_q;
                mem_wr_data_q <= fifo_q[rd_q];
            end

            if (is_start) begin
                rem_q <= bus.bus_data_1;
                if (bus.bus_data_1 == '0) begin
                    state_q     <= IDLE;
                    load_done_q <= 1'b1;
                end else begin
                    state_q <= STREAM;
                end
            end else begin
                case (state_q)
                    STREAM: begin
                        if (is_stream) begin
                            rem_q <= rem_q - k_ext;
                            if (rem_q == k_ext) begin
                                state_q <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        // Empty here means the final word went out on the previous edge.
                        if (cnt_q == 3'd0) begin
                            state_q     <= IDLE;
                            load_done_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign load_done   = load_done_q;
    assign err         = err_q;
    assign busy        = (state_q != IDLE) || (cnt_q != 3'd0);

endmodule

// File: tb/tb_cim_param_rx.sv
// Scoreboard bench for cim_param_rx: directed streams push expected writes into a
// queue that a negedge monitor pops whenever mem_wr_en is seen.
module tb_cim_param_rx;

    localparam int ID    = 5;
    localparam int NS    = 16;
    localparam int DEPTH = 528;
    localparam int AW    = $clog2(DEPTH);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 err_clr = 1'b0;
    logic                 mem_wr_en;
    logic [AW-1:0]        mem_wr_addr;
    logic signed [NS-1:0] mem_wr_data;
    logic                 busy;
    logic                 load_done;
    logic                 err;

    cim_param_rx_if #(.N_STORAGE(NS)) bif ();

    cim_param_rx #(.ID(ID), .N_STORAGE(NS), .MEM_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bif),
        .err_clr    (err_clr),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .busy       (busy),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_edge = 0;
    int first_edge = 0;
    int ld_cnt = 0;
    int ld_cyc = 0;
    int exp_ld = 0;
    int exp_addr[$];
    int exp_data[$];
    int wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int ea;
        int ed;
        if (mem_wr_en) begin
            if (exp_addr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %0d, required no write",
                         mem_wr_addr, mem_wr_data);
            end else begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                check("wr_addr", int'(mem_wr_addr), ea);
                check("wr_data", int'(mem_wr_data), ed);
            end
            wr_cyc.push_back(cyc);
        end
        if (load_done) begin
            ld_cnt++;
            ld_cyc = cyc;
            check("busy_at_load_done", int'(busy), 0);
        end
    end

    task automatic bus_cycle(input logic [4:0] op, input int tgt, input int d0, input int d1,
                             input int d2);
        bif.bus_op               = op;
        bif.bus_target_or_sender = 6'(tgt);
        bif.bus_data_0           = NS'(d0);
        bif.bus_data_1           = NS'(d1);
        bif.bus_data_2           = NS'(d2);
        @(posedge clk);
        #1;
        last_edge                = cyc;
        bif.bus_op               = 5'd0;
        bif.bus_target_or_sender = 6'd0;
        bif.bus_data_0           = '0;
        bif.bus_data_1           = '0;
        bif.bus_data_2           = '0;
    endtask

    task automatic start(input int tgt, input int base, input int len);
        bus_cycle(5'd1, tgt, base, len, 0);
    endtask

    task automatic stream(input int tgt, input int a, input int b, input int c);
        bus_cycle(5'd2, tgt, a, b, c);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_wr(input int addr, input int data);
        exp_addr.push_back(addr);
        exp_data.push_back(data);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_addr.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL %s_timeout: got %0d pending writes busy=%0d, required drained",
                     name, exp_addr.size(), busy);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bif.bus_op               = 5'd0;
        bif.bus_target_or_sender = 6'd0;
        bif.bus_data_0           = '0;
        bif.bus_data_1           = '0;
        bif.bus_data_2           = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ctrl_outputs", int'({mem_wr_en, busy, load_done, err}), 0);
        check("rst_wr_addr", int'(mem_wr_addr), 0);
        check("rst_wr_data", int'(mem_wr_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Basic stream: 7 words from 9 offered, latency and done timing
        wr_cyc.delete();
        for (int i = 0; i < 7; i++) expect_wr(10 + i, 1 + i);
        start(ID, 10, 7);
        stream(ID, 1, 2, 3);
        first_edge = last_edge;
        stream(ID, 4, 5, 6);
        stream(ID, 7, 8, 9);
        wait_idle("t1");
        exp_ld++;
        check("t1_load_done_count", ld_cnt, exp_ld);
        check("t1_err", int'(err), 0);
        check("t1_write_count", wr_cyc.size(), 7);
        check("t1_latency", wr_cyc[0], first_edge + 1);
        check("t1_done_timing", ld_cyc, wr_cyc[wr_cyc.size()-1] + 1);

        // Zero-length stream
        start(ID, 20, 0);
        @(negedge clk);
        check("t2_load_done", int'(load_done), 1);
        check("t2_busy", int'(busy), 0);
        check("t2_no_write", int'(mem_wr_en), 0);
        wait_idle("t2");
        exp_ld++;
        check("t2_load_done_count", ld_cnt, exp_ld);

        // Overflow: words 9, 11, 12 dropped
        wr_cyc.delete();
        for (int i = 0; i < 8; i++) expect_wr(100 + i, 1 + i);
        expect_wr(108, 10);
        start(ID, 100, 12);
        stream(ID, 1, 2, 3);
        stream(ID, 4, 5, 6);
        stream(ID, 7, 8, 9);
        stream(ID, 10, 11, 12);
        wait_idle("t3");
        exp_ld++;
        check("t3_load_done_count", ld_cnt, exp_ld);
        check("t3_write_count", wr_cyc.size(), 9);
        check("t3_err_set", int'(err), 1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("t3_err_clr", int'(err), 0);

        // Stray stream op while idle, with err_clr in the same cycle
        err_clr = 1'b1;
        stream(ID, 0, 0, 0);
        err_clr = 1'b0;
        check("stray_err_set_wins", int'(err), 1);
        check("stray_busy", int'(busy), 0);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("stray_err_clr", int'(err), 0);

        // Address wrap
        expect_wr(526, 1);
        expect_wr(527, 2);
        expect_wr(0, 3);
        expect_wr(1, 4);
        start(ID, 526, 4);
        stream(ID, 1, 2, 3);
        stream(ID, 4, 0, 0);
        wait_idle("t4");
        exp_ld++;
        check("t4_load_done_count", ld_cnt, exp_ld);
        check("t4_err_wrap", int'(err), 1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;

        // Ops for another target interleaved with our stream
        start(6, 0, 3);
        stream(6, 9, 9, 9);
        check("t5_foreign_idle_err", int'(err), 0);
        check("t5_foreign_idle_busy", int'(busy), 0);
        for (int i = 0; i < 5; i++) expect_wr(200 + i, 1 + i);
        start(ID, 200, 5);
        start(6, 300, 2);
        stream(ID, 1, 2, 3);
        stream(6, 9, 9, 9);
        bus_cycle(5'd3, ID, 55, 55, 55);
        stream(ID, 4, 5, 7);
        wait_idle("t5");
        exp_ld++;
        check("t5_load_done_count", ld_cnt, exp_ld);
        check("t5_err", int'(err), 0);

        // Restart after two words written
        expect_wr(300, 1);
        expect_wr(301, 2);
        expect_wr(400, 7);
        expect_wr(401, 8);
        expect_wr(402, 9);
        start(ID, 300, 6);
        stream(ID, 1, 2, 3);
        idle(2);
        start(ID, 400, 3);
        stream(ID, 7, 8, 9);
        wait_idle("t6");
        exp_ld++;
        check("t6_load_done_count", ld_cnt, exp_ld);
        check("t6_err_restart", int'(err), 1);

        // Reset mid-stream; err left set so reset must clear it
        start(ID, 50, 6);
        stream(ID, 1, 2, 3);
        rst_n = 1'b0;
        #1;
        check("t7_rst_async", int'({mem_wr_en, busy, load_done, err}), 0);
        @(negedge clk);
        check("t7_rst_ctrl", int'({mem_wr_en, busy, load_done, err}), 0);
        check("t7_rst_addr", int'(mem_wr_addr), 0);
        check("t7_rst_data", int'(mem_wr_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t7_no_write_after_release", int'(mem_wr_en), 0);
        check("t7_busy_after_release", int'(busy), 0);
        expect_wr(60, 11);
        expect_wr(61, 12);
        start(ID, 60, 2);
        stream(ID, 11, 12, 0);
        wait_idle("t7");
        exp_ld++;
        check("t7_load_done_count", ld_cnt, exp_ld);
        check("t7_err", int'(err), 0);

        check("scoreboard_empty", exp_addr.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
